// File: rtl/systolic_matmul_host_if.sv
// Host-side request/result streams of the systolic matmul host: operands in, 2x2 product out.
interface systolic_matmul_host_if;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_a;
   logic [15:0] s_b;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_c;

   modport master (
      output s_valid, s_a, s_b, m_ready,
      input  s_ready, m_valid, m_c
   );

   modport slave (
      input  s_valid, s_a, s_b, m_ready,
      output s_ready, m_valid, m_c
   );
endinterface

// File: rtl/systolic_matmul_host.sv
// Drives 2x2 operands onto the accelerator pins for HOLD cycles each, then reassembles the two result beats;
// one request in flight, s_ready low until the result is taken. SYSTOLIC_HOST_CHECK_EN adds chk_mismatch.
module systolic_matmul_host #(
   parameter int TIMEOUT = 64,
   parameter int HOLD    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_matmul_host_if.slave host,
   output logic                  err_reject,
   output logic                  err_timeout,
   output logic [7:0]            acc_ui_in,
   output logic [7:0]            acc_uio_in,
   input  logic [7:0]            acc_uo_out,
   input  logic [7:0]            acc_uio_out,
   input  logic [7:0]            acc_uio_oe
`ifdef SYSTOLIC_HOST_CHECK_EN
   ,
   output logic                  chk_mismatch
`endif
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, DRIVE_A, DRIVE_B, WAIT_OE, CAP2, HOLD_RES} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   b_q, b_d;
   logic [7:0]    ui_q, ui_d, uio_q, uio_d;
   logic          s_ready_q, s_ready_d;
   logic          m_valid_q, m_valid_d;
   logic [31:0]   m_c_q, m_c_d;
   logic          err_reject_q, err_reject_d;
   logic          err_timeout_q, err_timeout_d;
   logic          oe_prev_q, oe_prev_d;

   logic          oe_hi, oe_rise, zero_row, last_hold, last_wait;
   logic [15:0]   beat;

   assign oe_hi     = (acc_uio_oe == 8'hFF);
   assign oe_rise   = oe_hi && !oe_prev_q;
   // uio_out carries the high nibbles, uo_out the low nibbles of the two elements in a beat
   assign beat      = {acc_uio_out[7:4], acc_uo_out[7:4], acc_uio_out[3:0], acc_uo_out[3:0]};
   assign zero_row  = (host.s_a[15:8] == 8'h00) || (host.s_a[7:0] == 8'h00) ||
                      (host.s_b[15:8] == 8'h00) || (host.s_b[7:0] == 8'h00);
   assign last_hold = (cnt_q == CW'(HOLD - 1));
   assign last_wait = (cnt_q == CW'(TIMEOUT - 1));

`ifdef SYSTOLIC_HOST_CHECK_EN
   logic [15:0] a_q, a_d;
   logic        chk_q, chk_d;

   function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
      return {4'b0, x} * {4'b0, y};
   endfunction

   function automatic logic [31:0] expect_c(input logic [15:0] a, input logic [15:0] b);
      logic [7:0] c00, c01, c10, c11;
      c00 = mul4(a[15:12], b[15:12]) + mul4(a[11:8], b[7:4]);
      c01 = mul4(a[15:12], b[11:8])  + mul4(a[11:8], b[3:0]);
      c10 = mul4(a[7:4],   b[15:12]) + mul4(a[3:0],  b[7:4]);
      c11 = mul4(a[7:4],   b[11:8])  + mul4(a[3:0],  b[3:0]);
      return {c00, c01, c10, c11};
   endfunction
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      b_d           = b_q;
      ui_d          = ui_q;
      uio_d         = uio_q;
      m_valid_d     = m_valid_q;
      m_c_d         = m_c_q;
      err_reject_d  = 1'b0;
      err_timeout_d = 1'b0;
      oe_prev_d     = oe_hi;
`ifdef SYSTOLIC_HOST_CHECK_EN
      a_d           = a_q;
      chk_d         = chk_q;
`endif
      case (state_q)
         IDLE: begin
            ui_d  = 8'h00;
            uio_d = 8'h00;
            cnt_d = '0;
            if (host.s_valid && s_ready_q) begin
               if (zero_row) begin
                  err_reject_d = 1'b1;
               end else begin
                  b_d     = host.s_b;
                  ui_d    = host.s_a[15:8];
                  uio_d   = host.s_a[7:0];
                  state_d = DRIVE_A;
`ifdef SYSTOLIC_HOST_CHECK_EN
                  a_d     = host.s_a;
`endif
               end
            end
         end
         DRIVE_A: begin
            if (last_hold) begin
               cnt_d   = '0;
               ui_d    = b_q[15:8];
               uio_d   = b_q[7:0];
               state_d = DRIVE_B;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRIVE_B: begin
            if (last_hold) begin
               cnt_d   = '0;
               ui_d    = 8'h00;
               uio_d   = 8'h00;
               state_d = WAIT_OE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_OE: begin
            if (oe_rise) begin
               m_c_d[31:16] = beat;
               state_d      = CAP2;
            end else if (last_wait) begin
               err_timeout_d = 1'b1;
               cnt_d         = '0;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAP2: begin
            m_c_d[15:0] = beat;
            m_valid_d   = 1'b1;
            state_d     = HOLD_RES;
`ifdef SYSTOLIC_HOST_CHECK_EN
            chk_d       = ({m_c_q[31:16], beat} != expect_c(a_q, b_q));
`endif
         end
         HOLD_RES: begin
            if (host.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      s_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         b_q           <= '0;
         ui_q          <= '0;
         uio_q         <= '0;
         s_ready_q     <= 1'b0;
         m_valid_q     <= 1'b0;
         m_c_q         <= '0;
         err_reject_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         oe_prev_q     <= 1'b0;
`ifdef SYSTOLIC_HOST_CHECK_EN
         a_q           <= '0;
         chk_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         b_q           <= b_d;
         ui_q          <= ui_d;
         uio_q         <= uio_d;
         s_ready_q     <= s_ready_d;
         m_valid_q     <= m_valid_d;
         m_c_q         <= m_c_d;
         err_reject_q  <= err_reject_d;
         err_timeout_q <= err_timeout_d;
         oe_prev_q     <= oe_prev_d;
`ifdef SYSTOLIC_HOST_CHECK_EN
         a_q           <= a_d;
         chk_q         <= chk_d;
`endif
      end
   end

   assign host.s_ready = s_ready_q;
   assign host.m_valid = m_valid_q;
   assign host.m_c     = m_c_q;
   assign err_reject   = err_reject_q;
   assign err_timeout  = err_timeout_q;
   assign acc_ui_in    = ui_q;
   assign acc_uio_in   = uio_q;
`ifdef SYSTOLIC_HOST_CHECK_EN
   assign chk_mismatch = chk_q;
`endif

endmodule
